// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Shared types and constants for the load/store unit: access-size and FSM
// state encodings, the default memory address width, and the request check.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam int MEM_AW_DEF = 10;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD     = 3'd1,
    S_ST     = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_RESP   = 3'd5
  } lsu_state_e;

  // Illegal size, misalignment, or a byte address beyond the memory window.
  function automatic logic lsu_req_err(input logic [1:0] size,
                                       input logic [31:0] addr,
                                       input int unsigned aw);
    logic bad_size;
    logic misalign;
    logic out_rng;
    bad_size = (size == SZ_ILL);
    misalign = ((size == SZ_H) && addr[0]) ||
               ((size == SZ_W) && (addr[1:0] != 2'b00));
    out_rng  = ((addr >> (aw + 2)) != 32'd0);
    return bad_size || misalign || out_rng;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_mem_ctrl_if.sv
// ============================================================================
// Module : lsu_req_if / lsu_mem_if
// CPU request/response bus and data-memory bus of the load/store unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface lsu_mem_if import lsu_pkg::*; #(
  parameter int AW = MEM_AW_DEF
);
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;

  modport master (
    output mem_addr, mem_we, mem_wd,
    input  mem_rd
  );

  modport slave (
    input  mem_addr, mem_we, mem_wd,
    output mem_rd
  );
endinterface

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
// Module : lsu_lane_align
// Combinational lane handling: load extract + sign/zero extend, store merge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_lane_align import lsu_pkg::*; (
  input  lsu_size_e   size,
  input  logic [1:0]  lane,
  input  logic        uns,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = word[{lane, 3'b000} +: 8];
    half_v  = lane[1] ? word[31:16] : word[15:0];
    ld_data = word;
    st_data = wdata;
    case (size)
      SZ_B: begin
        ld_data = {{24{~uns & byte_v[7]}}, byte_v};
        st_data = word;
        st_data[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        ld_data = {{16{~uns & half_v[15]}}, half_v};
        st_data = word;
        st_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        ld_data = word;
        st_data = wdata;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
// ============================================================================
// Module : lsu_mem_ctrl
// Load/store initiator for a single-port word memory; optional request
// counters are enabled with the LSU_STATS_EN macro.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_mem_ctrl import lsu_pkg::*; #(
  parameter int MEM_AW = MEM_AW_DEF,
  parameter int DATA_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  lsu_req_if.slave  cpu,
  lsu_mem_if.master mem
`ifdef LSU_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errs
`endif
);

  lsu_state_e          state_q, state_d;
  logic [MEM_AW-1:0]   word_q, word_d;
  logic [1:0]          lane_q, lane_d;
  lsu_size_e           size_q, size_d;
  logic                we_q, we_d;
  logic                uns_q, uns_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                accept;
  logic                req_err;
  logic [31:0]         align_word;
  logic [31:0]         ld_data;
  logic [31:0]         st_data;

  assign accept  = cpu.req_valid && (state_q == S_IDLE);
  assign req_err = lsu_req_err(cpu.req_size, cpu.req_addr, MEM_AW);

  // The merge needs the previously sampled word; loads extract straight from memory.
  assign align_word = (state_q == S_RMW_WR) ? rdata_q : mem.mem_rd;

  lsu_lane_align u_align (
    .size    (size_q),
    .lane    (lane_q),
    .uns     (uns_q),
    .word    (align_word),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                              state_d = S_RESP;
          else if (!cpu.req_we)                     state_d = S_LD;
          else if (cpu.req_size == SZ_W)            state_d = S_ST;
          else                                      state_d = S_RMW_RD;
        end
      end
      S_LD, S_ST, S_RMW_WR: state_d = S_RESP;
      S_RMW_RD:             state_d = S_RMW_WR;
      S_RESP:               state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  always_comb begin
    word_d  = word_q;
    lane_d  = lane_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (accept) begin
      word_d  = cpu.req_addr[MEM_AW+1:2];
      lane_d  = cpu.req_addr[1:0];
      size_d  = lsu_size_e'(cpu.req_size);
      we_d    = cpu.req_we;
      uns_d   = cpu.req_unsigned;
      err_d   = req_err;
      wdata_d = cpu.req_wdata;
      rdata_d = '0;
    end else if (state_q == S_LD) begin
      rdata_d = ld_data;
    end else if (state_q == S_RMW_RD) begin
      rdata_d = mem.mem_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q  <= '0;
      lane_q  <= '0;
      size_q  <= SZ_B;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      word_q  <= word_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    cpu.req_ready = (state_q == S_IDLE);
    cpu.rsp_valid = (state_q == S_RESP);
    cpu.rsp_err   = (state_q == S_RESP) && err_q;
    cpu.rsp_rdata = ((state_q == S_RESP) && !err_q && !we_q) ? rdata_q : '0;
    mem.mem_addr  = '0;
    mem.mem_we    = 1'b0;
    mem.mem_wd    = '0;
    case (state_q)
      S_LD, S_RMW_RD: mem.mem_addr = word_q;
      S_ST: begin
        mem.mem_addr = word_q;
        mem.mem_we   = 1'b1;
        mem.mem_wd   = wdata_q;
      end
      S_RMW_WR: begin
        mem.mem_addr = word_q;
        mem.mem_we   = 1'b1;
        mem.mem_wd   = st_data;
      end
      default: ;
    endcase
  end

`ifdef LSU_STATS_EN
  logic [15:0] loads_q, loads_d;
  logic [15:0] stores_q, stores_d;
  logic [15:0] errs_q, errs_d;

  always_comb begin
    loads_d  = loads_q;
    stores_d = stores_q;
    errs_d   = errs_q;
    if (state_q == S_RESP) begin
      if (err_q) begin
        if (errs_q != 16'hFFFF) errs_d = errs_q + 16'd1;
      end else if (we_q) begin
        if (stores_q != 16'hFFFF) stores_d = stores_q + 16'd1;
      end else begin
        if (loads_q != 16'hFFFF) loads_d = loads_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loads_q  <= '0;
      stores_q <= '0;
      errs_q   <= '0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
      errs_q   <= errs_d;
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errs   = errs_q;
`endif

endmodule

`default_nettype wire
